// File: rtl/dpll_scan_ctrl_if.sv
// Scan test control/status bundle between a test host and
// dpll_scan_ctrl, plus the serial chain pins.
interface dpll_scan_ctrl_if #(
  parameter int CHAIN_LEN = 32,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
);
  logic                 start;
  logic                 abort;
  logic                 mode;
  logic [CHAIN_LEN-1:0] pattern;
  logic [CHAIN_LEN-1:0] expected;
  logic [7:0]           capture_cycles;
  logic                 scan_out;
  logic                 scan_en;
  logic                 scan_in;
  logic                 busy;
  logic                 done;
  logic [CHAIN_LEN-1:0] result;
  logic [CNT_W-1:0]     mismatch_cnt;
  logic                 pass;

  modport master (
    output start, abort, mode, pattern, expected,
    output capture_cycles, scan_out,
    input  scan_en, scan_in, busy, done,
    input  result, mismatch_cnt, pass
  );

  modport slave (
    input  start, abort, mode, pattern, expected,
    input  capture_cycles, scan_out,
    output scan_en, scan_in, busy, done,
    output result, mismatch_cnt, pass
  );
endinterface

// File: rtl/dpll_scan_ctrl.sv
// Scan-chain test initiator for the DPLL: shift in, optional
// functional capture, shift out and compare.
module dpll_scan_ctrl #(
  parameter int CHAIN_LEN = 32,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input logic             clk,
  input logic             rst,
  dpll_scan_ctrl_if.slave sif
);

  typedef enum logic [2:0] {
    IDLE, SHIFT_IN, CAPTURE, UNLOAD, DONE
  } state_t;

  state_t               state, state_nxt;
  logic [CHAIN_LEN-1:0] pos, pos_nxt;
  logic [CHAIN_LEN-1:0] pat_q, cmp_q, res_q;
  logic [CHAIN_LEN-1:0] pat_src;
  logic [7:0]           cap_q;
  logic                 mode_q;
  logic [CNT_W-1:0]     mm_q, mm_nxt;
  logic                 pass_q;
  logic                 en_q, in_q;
  logic                 en_nxt, in_nxt;
  logic                 run, accept, diff;

  assign run    = (state == SHIFT_IN) ||
                  (state == CAPTURE) ||
                  (state == UNLOAD);
  assign accept = (state == IDLE) && sif.start;
  assign diff   = (|(pos & cmp_q)) != sif.scan_out;

  always_comb begin
    state_nxt = state;
    pos_nxt   = pos;
    unique case (state)
      IDLE: begin
        if (sif.start) begin
          state_nxt = SHIFT_IN;
          pos_nxt   = {{(CHAIN_LEN-1){1'b0}}, 1'b1};
        end
      end
      SHIFT_IN: begin
        pos_nxt = {pos[CHAIN_LEN-2:0], pos[CHAIN_LEN-1]};
        if (sif.abort)
          state_nxt = IDLE;
        else if (pos[CHAIN_LEN-1])
          state_nxt = mode_q ? CAPTURE : UNLOAD;
      end
      CAPTURE: begin
        if (sif.abort)
          state_nxt = IDLE;
        else if (cap_q == 8'd0)
          state_nxt = UNLOAD;
      end
      UNLOAD: begin
        pos_nxt = {pos[CHAIN_LEN-2:0], pos[CHAIN_LEN-1]};
        if (sif.abort)
          state_nxt = IDLE;
        else if (pos[CHAIN_LEN-1])
          state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Chain pins are registered, so they are decoded from the next state.
  always_comb begin
    pat_src = (state == IDLE) ? sif.pattern : pat_q;
    en_nxt  = (state_nxt == SHIFT_IN) ||
              (state_nxt == UNLOAD);
    in_nxt  = (state_nxt == SHIFT_IN) &&
              (|(pat_src & pos_nxt));
    mm_nxt  = mm_q;
    if ((state == UNLOAD) && !sif.abort && diff)
      mm_nxt = mm_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      pos    <= '0;
      pat_q  <= '0;
      cmp_q  <= '0;
      res_q  <= '0;
      cap_q  <= '0;
      mode_q <= 1'b0;
      mm_q   <= '0;
      pass_q <= 1'b0;
      en_q   <= 1'b0;
      in_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      pos   <= pos_nxt;
      en_q  <= en_nxt;
      in_q  <= in_nxt;
      if (accept) begin
        mode_q <= sif.mode;
        pat_q  <= sif.pattern;
        cmp_q  <= sif.mode ? sif.expected : sif.pattern;
        cap_q  <= (sif.capture_cycles == 8'd0) ? 8'd0 :
                  sif.capture_cycles - 8'd1;
        mm_q   <= '0;
        pass_q <= 1'b0;
      end
      if ((state == CAPTURE) && (cap_q != 8'd0))
        cap_q <= cap_q - 8'd1;
      if ((state == UNLOAD) && !sif.abort) begin
        res_q <= (res_q & ~pos) |
                 (pos & {CHAIN_LEN{sif.scan_out}});
        mm_q  <= mm_nxt;
      end
      if (state_nxt == DONE)
        pass_q <= (mm_nxt == '0);
      if (run && sif.abort)
        pass_q <= 1'b0;
    end
  end

  assign sif.scan_en      = en_q;
  assign sif.scan_in      = in_q;
  assign sif.busy         = run;
  assign sif.done         = (state == DONE);
  assign sif.result       = res_q;
  assign sif.mismatch_cnt = mm_q;
  assign sif.pass         = pass_q;

endmodule

// File: tb/tb_dpll_scan_ctrl.sv
// Bench for dpll_scan_ctrl with an 8-flop behavioural chain.
// Table-driven runs plus abort, reset and start-hold sequences.
module tb_dpll_scan_ctrl;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dpll_scan_ctrl_if #(.CHAIN_LEN(N), .CNT_W(4)) sif ();

  dpll_scan_ctrl #(.CHAIN_LEN(N), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .sif (sif)
  );

  logic [N-1:0] chain;
  logic         stuck;
  logic         cap_load;

  always @(posedge clk) begin
    if (rst)
      chain <= '0;
    else if (sif.scan_en)
      chain <= {sif.scan_in, chain[N-1:1]};
    else if (cap_load)
      chain <= 8'h3C;
  end

  assign sif.scan_out = stuck ? 1'b0 : chain[0];

  typedef struct {
    logic       mode;
    logic [7:0] pat;
    logic [7:0] exp_v;
    logic [7:0] cc;
    logic       stk;
    logic       cload;
    int         lat;
    logic [7:0] res;
    int         mm;
    logic       ps;
    int         en_lo;
  } vec_t;

  vec_t vt[6];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  task automatic run(input vec_t v, input int idx);
    int n, hi, lo;
    sif.mode           = v.mode;
    sif.pattern        = v.pat;
    sif.expected       = v.exp_v;
    sif.capture_cycles = v.cc;
    stuck              = v.stk;
    cap_load           = v.cload;
    sif.start          = 1'b1;
    @(posedge clk);
    #1;
    sif.start = 1'b0;
    chk($sformatf("v%0d_first_en", idx), 32'(sif.scan_en), 1);
    chk($sformatf("v%0d_first_in", idx), 32'(sif.scan_in), 32'(v.pat[0]));
    n = 1; hi = 0; lo = 0;
    while (!sif.done && n < 100) begin
      if (sif.busy) begin
        if (sif.scan_en) hi++;
        else lo++;
      end
      @(posedge clk);
      #1;
      n++;
    end
    chk($sformatf("v%0d_latency", idx), 32'(n), 32'(v.lat));
    chk($sformatf("v%0d_busy_done", idx), 32'(sif.busy), 0);
    chk($sformatf("v%0d_result", idx), 32'(sif.result), 32'(v.res));
    chk($sformatf("v%0d_mm", idx), 32'(sif.mismatch_cnt), 32'(v.mm));
    chk($sformatf("v%0d_pass", idx), 32'(sif.pass), 32'(v.ps));
    chk($sformatf("v%0d_en_hi", idx), 32'(hi), 2 * N);
    chk($sformatf("v%0d_en_lo", idx), 32'(lo), 32'(v.en_lo));
    @(posedge clk);
    #1;
    chk($sformatf("v%0d_done_pulse", idx), 32'(sif.done), 0);
    chk($sformatf("v%0d_pass_hold", idx), 32'(sif.pass), 32'(v.ps));
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_en"},   32'(sif.scan_en), 0);
    chk({nm, "_in"},   32'(sif.scan_in), 0);
    chk({nm, "_busy"}, 32'(sif.busy), 0);
    chk({nm, "_done"}, 32'(sif.done), 0);
    chk({nm, "_res"},  32'(sif.result), 0);
    chk({nm, "_mm"},   32'(sif.mismatch_cnt), 0);
    chk({nm, "_pass"}, 32'(sif.pass), 0);
  endtask

  initial begin
    int n, dn;
    vt[0] = '{1'b0, 8'hA5, 8'h00, 8'd0, 1'b0, 1'b0, 17, 8'hA5, 0, 1'b1, 0};
    vt[1] = '{1'b0, 8'hFF, 8'h00, 8'd0, 1'b1, 1'b0, 17, 8'h00, 8, 1'b0, 0};
    vt[2] = '{1'b1, 8'h0F, 8'h3C, 8'd3, 1'b0, 1'b1, 20, 8'h3C, 0, 1'b1, 3};
    vt[3] = '{1'b1, 8'h0F, 8'h3D, 8'd3, 1'b0, 1'b1, 20, 8'h3C, 1, 1'b0, 3};
    vt[4] = '{1'b1, 8'h0F, 8'h3C, 8'd0, 1'b0, 1'b1, 18, 8'h3C, 0, 1'b1, 1};
    vt[5] = '{1'b0, 8'h96, 8'h00, 8'd0, 1'b0, 1'b0, 17, 8'h96, 0, 1'b1, 0};

    sif.start = 1'b0; sif.abort = 1'b0; sif.mode = 1'b0;
    sif.pattern = '0; sif.expected = '0; sif.capture_cycles = '0;
    stuck = 1'b0; cap_load = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_reset_vals("reset");

    for (int i = 0; i < 6; i++) run(vt[i], i);

    // Abort in UNLOAD cycle 3 (cycle 12 after the start edge)
    sif.mode = 1'b0; sif.pattern = 8'hA5; stuck = 1'b0; cap_load = 1'b0;
    sif.start = 1'b1;
    @(posedge clk);
    #1;
    sif.start = 1'b0;
    for (n = 1; n < 12; n++) begin
      @(posedge clk);
      #1;
    end
    sif.abort = 1'b1;
    @(posedge clk);
    #1;
    sif.abort = 1'b0;
    chk("abort_busy", 32'(sif.busy), 0);
    chk("abort_en",   32'(sif.scan_en), 0);
    chk("abort_in",   32'(sif.scan_in), 0);
    chk("abort_pass", 32'(sif.pass), 0);
    dn = 0;
    for (int k = 0; k < 25; k++) begin
      if (sif.done) dn++;
      @(posedge clk);
      #1;
    end
    chk("abort_no_done", 32'(dn), 0);
    run(vt[0], 10);

    // Reset during SHIFT_IN cycle 2
    sif.pattern = 8'h5A;
    sif.start = 1'b1;
    @(posedge clk);
    #1;
    sif.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("pre_rst_busy", 32'(sif.busy), 1);
    rst = 1'b1;
    sif.start = 1'b1;
    sif.abort = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sif.start = 1'b0;
    sif.abort = 1'b0;
    chk_reset_vals("midrst");

    // start held high through busy and DONE
    sif.mode = 1'b0; sif.pattern = 8'hC3;
    sif.start = 1'b1;
    @(posedge clk);
    #1;
    n = 1;
    while (!sif.done && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("hold_latency", 32'(n), 17);
    chk("hold_result", 32'(sif.result), 32'h0C3);
    @(posedge clk);
    #1;
    sif.start = 1'b0;
    chk("hold_no_rerun", 32'(sif.busy), 0);
    dn = 0;
    for (int k = 0; k < 20; k++) begin
      if (sif.done || sif.busy) dn++;
      @(posedge clk);
      #1;
    end
    chk("hold_idle", 32'(dn), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule
